// File: rtl/l1_word_cache.sv
// l1_word_cache: direct-mapped, write-through, no-write-allocate cache of
// NUM_LINES one-word lines placed in front of a variable-latency backing memory.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   mem_read/mem_write   CPU request, held by the requester until mem_resp
//   mem_byte_enable      CPU write byte lanes
//   mem_address          CPU byte address; bits [1:0] are ignored
//   mem_wdata            CPU write data
//   mem_rdata            CPU read data, held between responses
//   mem_resp             one-cycle completion pulse
//   pmem_*               backing-memory request (held until pmem_resp) and response
module l1_word_cache #(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam int unsigned IDXW = $clog2(NUM_LINES);
  localparam int unsigned TAGW = 30 - IDXW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_e;

  state_e state_q, state_d;

  logic            valid_q [NUM_LINES];
  logic [TAGW-1:0] tag_q   [NUM_LINES];
  logic [31:0]     data_q  [NUM_LINES];

  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_resp_q;
  logic        pmem_read_q, pmem_write_q;
  logic [31:0] pmem_address_q, pmem_wdata_q;
  logic [3:0]  pmem_be_q;

  // Masking the byte offset keeps the whole address in use while ignoring bits [1:0].
  logic [31:0]     word_addr;
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            fill_we;
  logic            upd_we;

  assign word_addr = mem_address & 32'hFFFF_FFFC;
  assign idx       = word_addr[IDXW+1:2];
  assign tag       = word_addr[31:IDXW+2];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);

  // Next-state and line-update decode.
  always_comb begin
    state_d     = state_q;
    mem_rdata_d = mem_rdata_q;
    fill_we     = 1'b0;
    upd_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_write) begin
          state_d = WRITE;
        end else if (mem_read) begin
          if (hit) begin
            state_d     = RESP;
            mem_rdata_d = data_q[idx];
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (pmem_resp) begin
          state_d     = RESP;
          mem_rdata_d = pmem_rdata;
          fill_we     = 1'b1;
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          state_d = RESP;
          upd_we  = hit;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, valid bits and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mem_rdata_q    <= 32'h0;
      mem_resp_q     <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 32'h0;
      pmem_wdata_q   <= 32'h0;
      pmem_be_q      <= 4'h0;
      for (int i = 0; i < NUM_LINES; i++) valid_q[i] <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_resp_q     <= (state_d == RESP);
      pmem_read_q    <= (state_d == FILL);
      pmem_write_q   <= (state_d == WRITE);
      pmem_address_q <= ((state_d == FILL) || (state_d == WRITE)) ? word_addr : 32'h0;
      pmem_wdata_q   <= (state_d == WRITE) ? mem_wdata : 32'h0;
      pmem_be_q      <= (state_d == WRITE) ? mem_byte_enable : 4'h0;
      if (fill_we) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (rst_n && fill_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= pmem_rdata;
    end else if (rst_n && upd_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b]) data_q[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign mem_rdata        = mem_rdata_q;
  assign mem_resp         = mem_resp_q;
  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_address     = pmem_address_q;
  assign pmem_wdata       = pmem_wdata_q;
  assign pmem_byte_enable = pmem_be_q;

endmodule

// File: tb/tb_l1_word_cache.sv
// Directed bench for l1_word_cache with a variable-latency backing-memory responder.
module tb_l1_word_cache;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_byte_enable;
  logic        pmem_resp;

  always #5 clk = ~clk;

  l1_word_cache #(.NUM_LINES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Backing memory model, keyed by word address.
  logic [31:0] bmem [logic [29:0]];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_fill = 0;
  int          n_wr = 0;
  int          fill_cyc = 0;
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_be;
  logic [31:0] exp_rdata;

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (bmem.exists(wa)) return bmem[wa];
    return 32'hB000_0000 ^ {2'b00, wa};
  endfunction

  // Responder: answers each pmem request LAT cycles after it appears; junk data otherwise.
  initial begin
    int cnt;
    logic [31:0] w;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = $urandom;
      if (rst_n === 1'b1 && (pmem_read || pmem_write)) begin
        if (pmem_read) fill_cyc++;
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_read) begin
            pmem_rdata = mem_rd(pmem_address[31:2]);
            n_fill++;
          end else begin
            w = mem_rd(pmem_address[31:2]);
            for (int b = 0; b < 4; b++)
              if (pmem_byte_enable[b]) w[8*b +: 8] = pmem_wdata[8*b +: 8];
            bmem[pmem_address[31:2]] = w;
            last_waddr = pmem_address;
            last_wdata = pmem_wdata;
            last_be    = pmem_byte_enable;
            n_wr++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (mem_resp !== 1'b1 && cyc < 50);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input int fills, input int lat);
    int f0, cyc;
    logic [31:0] e;
    f0 = n_fill;
    exp_q.push_back(mem_rd(a[31:2]));
    mem_address = a;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    wait_resp(cyc);
    chk({tag, "_resp"}, 32'(mem_resp), 32'd1);
    e = exp_q.pop_front();
    exp_rdata = e;
    chk({tag, "_rdata"}, mem_rdata, e);
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_fills"}, 32'(n_fill - f0), 32'(fills));
    mem_read = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(mem_resp), 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic also_rd);
    int w0, f0, cyc;
    w0 = n_wr;
    f0 = n_fill;
    mem_address     = a;
    mem_wdata       = wd;
    mem_byte_enable = be;
    mem_write       = 1'b1;
    mem_read        = also_rd;
    wait_resp(cyc);
    chk({tag, "_resp"}, 32'(mem_resp), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(LAT + 1));
    chk({tag, "_writes"}, 32'(n_wr - w0), 32'd1);
    chk({tag, "_fills"}, 32'(n_fill - f0), 32'd0);
    chk({tag, "_paddr"}, last_waddr, a & 32'hFFFF_FFFC);
    chk({tag, "_pwdata"}, last_wdata, wd);
    chk({tag, "_pbe"}, 32'(last_be), 32'(be));
    chk({tag, "_rdata_held"}, mem_rdata, exp_rdata);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(mem_resp), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0, c0;
    logic saw;
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 4'h0;
    mem_address = 32'h0;
    mem_wdata = 32'h0;
    exp_rdata = 32'h0;
    bmem[30'(32'h100 >> 2)] = 32'hDEAD_BEEF;
    bmem[30'(32'h120 >> 2)] = 32'h1201_2012;
    repeat (3) @(negedge clk);
    chk("rst_mem_resp", 32'(mem_resp), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_pmem_write", 32'(pmem_write), 32'd0);
    chk("rst_pmem_addr", pmem_address, 32'h0);
    chk("rst_pmem_wdata", pmem_wdata, 32'h0);
    chk("rst_pmem_be", 32'(pmem_byte_enable), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, then hit.
    c0 = fill_cyc;
    do_read("r100_miss", 32'h100, 1, LAT + 1);
    chk("r100_miss_const", mem_rdata, 32'hDEAD_BEEF);
    chk("r100_pmem_read_cycles", 32'(fill_cyc - c0), 32'(LAT));
    do_read("r100_hit", 32'h100, 0, 1);
    chk("r100_hit_const", mem_rdata, 32'hDEAD_BEEF);

    // Partial write-through to a cached line, then zero-lane write.
    do_write("w100_be3", 32'h100, 32'h1122_3344, 4'b0011, 1'b0);
    do_read("r100_after_w", 32'h100, 0, 1);
    chk("r100_after_w_const", mem_rdata, 32'hDEAD_3344);
    do_write("w100_be0", 32'h102, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    do_read("r100_after_be0", 32'h100, 0, 1);
    chk("r100_after_be0_const", mem_rdata, 32'hDEAD_3344);

    // Aliasing index: 0x120 evicts 0x100.
    do_read("r120_miss", 32'h120, 1, LAT + 1);
    chk("r120_const", mem_rdata, 32'h1201_2012);
    do_read("r100_evicted", 32'h100, 1, LAT + 1);
    chk("r100_evicted_const", mem_rdata, 32'hDEAD_3344);

    // Write miss (with read also asserted) does not allocate.
    do_write("w200_miss", 32'h200, 32'hCAFE_F00D, 4'b1111, 1'b1);
    do_read("r200_miss", 32'h200, 1, LAT + 1);
    chk("r200_const", mem_rdata, 32'hCAFE_F00D);
    do_read("r200_hit", 32'h200, 0, 1);

    // Reset in the middle of a fill.
    f0 = n_fill;
    mem_address = 32'h300;
    mem_read = 1'b1;
    @(negedge clk);
    chk("rf_pmem_read_on", 32'(pmem_read), 32'd1);
    chk("rf_pmem_addr", pmem_address, 32'h300);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rf_pmem_read_off", 32'(pmem_read), 32'd0);
    chk("rf_pmem_addr_off", pmem_address, 32'h0);
    chk("rf_rdata_cleared", mem_rdata, 32'h0);
    mem_read = 1'b0;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_resp) saw = 1'b1;
    end
    chk("rf_no_resp", 32'(saw), 32'd0);
    chk("rf_no_fill", 32'(n_fill - f0), 32'd0);
    exp_rdata = 32'h0;
    do_read("r300_after_rst", 32'h300, 1, LAT + 1);
    do_read("r300_hit", 32'h300, 0, 1);
    do_read("r200_after_rst", 32'h200, 1, LAT + 1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
